// File: rtl/tri_raster_seq.sv
// Rasterizes one triangle at a time over its bounding box and streams pixels with an inside flag.
// A single edge-sign unit is time-shared across the three edges of each candidate pixel.
module tri_raster_seq #(
  parameter int CW       = 11,
  parameter int EMIT_ALL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tri_valid,
  output logic            tri_ready,
  input  logic [CW-1:0]   p1x,
  input  logic [CW-1:0]   p1y,
  input  logic [CW-1:0]   p2x,
  input  logic [CW-1:0]   p2y,
  input  logic [CW-1:0]   p3x,
  input  logic [CW-1:0]   p3y,
  output logic            pix_valid,
  input  logic            pix_ready,
  output logic [CW-1:0]   pix_x,
  output logic [CW-1:0]   pix_y,
  output logic            pix_inside,
  output logic            pix_last,
  output logic            busy,
  output logic            done,
  output logic [2*CW-1:0] inside_cnt
);

  localparam int PW   = 2*CW + 2;
  localparam int CNTW = 2*CW;
  localparam bit EMIT = (EMIT_ALL != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BBOX,
    S_E0,
    S_E1,
    S_E2,
    S_OUT
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_p1x, r_p1y, r_p2x, r_p2y, r_p3x, r_p3y;
  logic [CW-1:0]   r_xmin, r_xmax, r_ymin, r_ymax;
  logic [CW-1:0]   r_x, r_y;
  logic            r_s0, r_s1;
  logic            r_tri_ready, r_pix_valid, r_pix_inside, r_pix_last;
  logic            r_busy, r_done;
  logic [CNTW-1:0] r_inside_cnt;

  function automatic logic [CW-1:0] f_min3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                           input logic [CW-1:0] c);
    logic [CW-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [CW-1:0] f_max3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                           input logic [CW-1:0] c);
    logic [CW-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Edge operands: E0 -> (P1,P2), E1 -> (P2,P3), E2 -> (P3,P1).
  logic [CW-1:0] w_ax, w_ay, w_bx, w_by;
  always_comb begin
    w_ax = r_p1x;
    w_ay = r_p1y;
    w_bx = r_p2x;
    w_by = r_p2y;
    case (r_state)
      S_E1: begin
        w_ax = r_p2x;
        w_ay = r_p2y;
        w_bx = r_p3x;
        w_by = r_p3y;
      end
      S_E2: begin
        w_ax = r_p3x;
        w_ay = r_p3y;
        w_bx = r_p1x;
        w_by = r_p1y;
      end
      default: ;
    endcase
  end

  logic signed [CW:0]   w_dpx, w_dpy, w_dax, w_day;
  logic signed [PW-1:0] w_m1, w_m2;
  logic                 w_s, w_inside;

  assign w_dpx = {1'b0, r_x} - {1'b0, w_bx};
  assign w_dpy = {1'b0, r_y} - {1'b0, w_by};
  assign w_dax = {1'b0, w_ax} - {1'b0, w_bx};
  assign w_day = {1'b0, w_ay} - {1'b0, w_by};

  // Full-width sign-extended products: no truncation is possible at 2*CW+2 bits.
  assign w_m1 = $signed({{(CW+1){w_dpx[CW]}}, w_dpx}) * $signed({{(CW+1){w_day[CW]}}, w_day});
  assign w_m2 = $signed({{(CW+1){w_dax[CW]}}, w_dax}) * $signed({{(CW+1){w_dpy[CW]}}, w_dpy});
  assign w_s  = (w_m1 < w_m2);

  assign w_inside = (r_s0 == r_s1) && (r_s1 == w_s);

  logic          w_x_end, w_y_end, w_final;
  logic [CW-1:0] w_x_next, w_y_next;

  // Compare before incrementing so a box touching 2^CW-1 never wraps.
  assign w_x_end  = (r_x == r_xmax);
  assign w_y_end  = (r_y == r_ymax);
  assign w_final  = w_x_end && w_y_end;
  assign w_x_next = w_x_end ? r_xmin : (r_x + CW'(1));
  assign w_y_next = w_x_end ? (r_y + CW'(1)) : r_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_p1x        <= '0;
      r_p1y        <= '0;
      r_p2x        <= '0;
      r_p2y        <= '0;
      r_p3x        <= '0;
      r_p3y        <= '0;
      r_xmin       <= '0;
      r_xmax       <= '0;
      r_ymin       <= '0;
      r_ymax       <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_s0         <= 1'b0;
      r_s1         <= 1'b0;
      r_tri_ready  <= 1'b1;
      r_pix_valid  <= 1'b0;
      r_pix_inside <= 1'b0;
      r_pix_last   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_inside_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (tri_valid && r_tri_ready) begin
            r_p1x        <= p1x;
            r_p1y        <= p1y;
            r_p2x        <= p2x;
            r_p2y        <= p2y;
            r_p3x        <= p3x;
            r_p3y        <= p3y;
            r_inside_cnt <= '0;
            r_busy       <= 1'b1;
            r_tri_ready  <= 1'b0;
            r_state      <= S_BBOX;
          end
        end
        S_BBOX: begin
          r_xmin  <= f_min3(r_p1x, r_p2x, r_p3x);
          r_xmax  <= f_max3(r_p1x, r_p2x, r_p3x);
          r_ymin  <= f_min3(r_p1y, r_p2y, r_p3y);
          r_ymax  <= f_max3(r_p1y, r_p2y, r_p3y);
          r_x     <= f_min3(r_p1x, r_p2x, r_p3x);
          r_y     <= f_min3(r_p1y, r_p2y, r_p3y);
          r_state <= S_E0;
        end
        S_E0: begin
          r_s0    <= w_s;
          r_state <= S_E1;
        end
        S_E1: begin
          r_s1    <= w_s;
          r_state <= S_E2;
        end
        S_E2: begin
          if (w_inside) begin
            r_inside_cnt <= r_inside_cnt + CNTW'(1);
          end
          if (EMIT || w_inside) begin
            r_pix_valid  <= 1'b1;
            r_pix_inside <= w_inside;
            r_pix_last   <= w_final;
            r_state      <= S_OUT;
          end else if (w_final) begin
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_tri_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_x     <= w_x_next;
            r_y     <= w_y_next;
            r_state <= S_E0;
          end
        end
        S_OUT: begin
          if (pix_ready) begin
            r_pix_valid <= 1'b0;
            if (w_final) begin
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_tri_ready <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_x     <= w_x_next;
              r_y     <= w_y_next;
              r_state <= S_E0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tri_ready  = r_tri_ready;
  assign pix_valid  = r_pix_valid;
  assign pix_x      = r_x;
  assign pix_y      = r_y;
  assign pix_inside = r_pix_inside;
  assign pix_last   = r_pix_last;
  assign busy       = r_busy;
  assign done       = r_done;
  assign inside_cnt = r_inside_cnt;

endmodule

// File: tb/tb_tri_raster_seq.sv
// Bench for tri_raster_seq: one instance emitting every box pixel, one emitting inside pixels only,
// checked every cycle against a pixel-list model built from the edge-sign rule.
module tb_tri_raster_seq;

  localparam int CW = 11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tri_valid = 1'b0;
  logic sel = 1'b0;
  logic pix_ready = 1'b1;
  logic [CW-1:0] p1x = '0, p1y = '0, p2x = '0, p2y = '0, p3x = '0, p3y = '0;

  logic a_tri_ready, a_pix_valid, a_pix_inside, a_pix_last, a_busy, a_done;
  logic b_tri_ready, b_pix_valid, b_pix_inside, b_pix_last, b_busy, b_done;
  logic [CW-1:0] a_pix_x, a_pix_y, b_pix_x, b_pix_y;
  logic [2*CW-1:0] a_inside_cnt, b_inside_cnt;
  logic tv_a, tv_b;

  assign tv_a = tri_valid & ~sel;
  assign tv_b = tri_valid & sel;

  tri_raster_seq #(.CW(CW), .EMIT_ALL(1)) dut_a (
    .clk(clk), .rst(rst), .tri_valid(tv_a), .tri_ready(a_tri_ready),
    .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .p3x(p3x), .p3y(p3y),
    .pix_valid(a_pix_valid), .pix_ready(pix_ready), .pix_x(a_pix_x), .pix_y(a_pix_y),
    .pix_inside(a_pix_inside), .pix_last(a_pix_last), .busy(a_busy), .done(a_done),
    .inside_cnt(a_inside_cnt)
  );

  tri_raster_seq #(.CW(CW), .EMIT_ALL(0)) dut_b (
    .clk(clk), .rst(rst), .tri_valid(tv_b), .tri_ready(b_tri_ready),
    .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .p3x(p3x), .p3y(p3y),
    .pix_valid(b_pix_valid), .pix_ready(pix_ready), .pix_x(b_pix_x), .pix_y(b_pix_y),
    .pix_inside(b_pix_inside), .pix_last(b_pix_last), .busy(b_busy), .done(b_done),
    .inside_cnt(b_inside_cnt)
  );

  logic m_tri_ready, m_pix_valid, m_pix_inside, m_pix_last, m_busy, m_done;
  logic [CW-1:0] m_pix_x, m_pix_y;
  logic [2*CW-1:0] m_inside_cnt;
  assign m_tri_ready  = sel ? b_tri_ready  : a_tri_ready;
  assign m_pix_valid  = sel ? b_pix_valid  : a_pix_valid;
  assign m_pix_inside = sel ? b_pix_inside : a_pix_inside;
  assign m_pix_last   = sel ? b_pix_last   : a_pix_last;
  assign m_busy       = sel ? b_busy       : a_busy;
  assign m_done       = sel ? b_done       : a_done;
  assign m_pix_x      = sel ? b_pix_x      : a_pix_x;
  assign m_pix_y      = sel ? b_pix_y      : a_pix_y;
  assign m_inside_cnt = sel ? b_inside_cnt : a_inside_cnt;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int pin_cnt = -1;
  int pin_npix = -1;
  int rdy_mode = 0;
  bit active = 1'b0;

  typedef struct {
    int x;
    int y;
    bit ins;
    bit last;
    int skips;
  } pix_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic bit sgn(longint px, longint py, longint ax, longint ay, longint bx, longint by);
    return ((px - bx) * (ay - by)) < ((ax - bx) * (py - by));
  endfunction

  function automatic int imin3(int a, int b, int c);
    int m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic int imax3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Model: list of expected emitted pixels, each tagged with the number of silently
  // skipped evaluations before it; every evaluation is 3 cycles, every emit adds an OUT cycle.
  initial begin : monitor
    pix_t q[$];
    pix_t it;
    int base, trail, model_cnt, hs, ntri;
    int last_cnt[2];
    int xmin, xmax, ymin, ymax;
    bit in_rst, exp_v, ins, emit;
    in_rst = 1'b0;
    base = 0; trail = 0; model_cnt = 0; hs = 0; ntri = 0;
    last_cnt[0] = 0;
    last_cnt[1] = 0;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        if (!in_rst) begin
          in_rst = 1'b1;
          #1;
          chk("rst_tri_ready", 64'(m_tri_ready), 64'(1));
          chk("rst_pix_valid", 64'(m_pix_valid), 64'(0));
          chk("rst_pix_inside", 64'(m_pix_inside), 64'(0));
          chk("rst_pix_last", 64'(m_pix_last), 64'(0));
          chk("rst_busy", 64'(m_busy), 64'(0));
          chk("rst_done", 64'(m_done), 64'(0));
          chk("rst_pix_x", 64'(m_pix_x), 64'(0));
          chk("rst_pix_y", 64'(m_pix_y), 64'(0));
          chk("rst_inside_cnt", 64'(m_inside_cnt), 64'(0));
          q.delete();
          active = 1'b0;
          last_cnt[0] = 0;
          last_cnt[1] = 0;
        end
      end else begin
        in_rst = 1'b0;
        if (!active) begin
          chk("idle_busy", 64'(m_busy), 64'(0));
          chk("idle_tri_ready", 64'(m_tri_ready), 64'(1));
          chk("idle_pix_valid", 64'(m_pix_valid), 64'(0));
          chk("idle_done", 64'(m_done), 64'(0));
          chk("idle_inside_cnt", 64'(m_inside_cnt), 64'(last_cnt[sel]));
          if (tri_valid && m_tri_ready === 1'b1) begin
            emit = (sel == 1'b0);
            xmin = imin3(int'(p1x), int'(p2x), int'(p3x));
            xmax = imax3(int'(p1x), int'(p2x), int'(p3x));
            ymin = imin3(int'(p1y), int'(p2y), int'(p3y));
            ymax = imax3(int'(p1y), int'(p2y), int'(p3y));
            q.delete();
            trail = 0;
            model_cnt = 0;
            for (int y = ymin; y <= ymax; y++) begin
              for (int x = xmin; x <= xmax; x++) begin
                ins = (sgn(x, y, p1x, p1y, p2x, p2y) == sgn(x, y, p2x, p2y, p3x, p3y)) &&
                      (sgn(x, y, p2x, p2y, p3x, p3y) == sgn(x, y, p3x, p3y, p1x, p1y));
                if (ins) model_cnt++;
                if (emit || ins) begin
                  it.x = x;
                  it.y = y;
                  it.ins = ins;
                  it.last = (x == xmax) && (y == ymax);
                  it.skips = trail;
                  q.push_back(it);
                  trail = 0;
                end else begin
                  trail++;
                end
              end
            end
            base = cyc + 2;
            hs = 0;
            active = 1'b1;
          end
        end else if (q.size() > 0) begin
          exp_v = (cyc >= base + 3 * (q[0].skips + 1));
          chk("pix_valid", 64'(m_pix_valid), 64'(exp_v));
          chk("busy", 64'(m_busy), 64'(1));
          chk("tri_ready_busy", 64'(m_tri_ready), 64'(0));
          chk("done_early", 64'(m_done), 64'(0));
          if (exp_v && m_pix_valid) begin
            chk("pix_x", 64'(m_pix_x), 64'(q[0].x));
            chk("pix_y", 64'(m_pix_y), 64'(q[0].y));
            chk("pix_inside", 64'(m_pix_inside), 64'(q[0].ins));
            chk("pix_last", 64'(m_pix_last), 64'(q[0].last));
            if (pix_ready) begin
              void'(q.pop_front());
              base = cyc + 1;
              hs++;
            end
          end
          if (cyc > base + 600) begin
            checks++;
            errors++;
            $display("FAIL watchdog: no pixel handshake for %0d cycles, required progress", cyc - base);
            active = 1'b0;
          end
        end else begin
          if (cyc == base + 3 * trail) begin
            chk("done", 64'(m_done), 64'(1));
            chk("done_busy", 64'(m_busy), 64'(0));
            chk("done_tri_ready", 64'(m_tri_ready), 64'(1));
            chk("inside_cnt", 64'(m_inside_cnt), 64'(model_cnt));
            if (pin_cnt >= 0) chk("pin_model_cnt", 64'(model_cnt), 64'(pin_cnt));
            if (pin_npix >= 0) chk("pin_npix", 64'(hs), 64'(pin_npix));
            $display("tri %0d sel=%0d pixels=%0d inside_cnt=%0d", ntri, sel, hs, m_inside_cnt);
            ntri++;
            last_cnt[sel] = model_cnt;
            active = 1'b0;
          end else begin
            chk("done_wait", 64'(m_done), 64'(0));
            chk("tail_busy", 64'(m_busy), 64'(1));
            chk("tail_pix_valid", 64'(m_pix_valid), 64'(0));
            if (cyc > base + 3 * trail) active = 1'b0;
          end
        end
      end
    end
  end

  // Ready driver: 0 always ready, 1 random, 2 stall 10 cycles on pixel (2,0), 3 never ready.
  initial begin : ready_drv
    int stall_n;
    stall_n = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: pix_ready = 1'b1;
        1: pix_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (m_pix_valid && m_pix_x == 2 && m_pix_y == 0 && stall_n < 10) begin
            pix_ready = 1'b0;
            stall_n++;
          end else begin
            pix_ready = 1'b1;
          end
        end
        default: pix_ready = 1'b0;
      endcase
      if (rdy_mode != 2) stall_n = 0;
    end
  end

  task automatic send_tri(input int x1, input int y1, input int x2, input int y2,
                          input int x3, input int y3, input int pc, input int pn,
                          input bit wait_done);
    int n;
    @(posedge clk);
    #1;
    p1x = CW'(x1); p1y = CW'(y1);
    p2x = CW'(x2); p2y = CW'(y2);
    p3x = CW'(x3); p3y = CW'(y3);
    pin_cnt = pc;
    pin_npix = pn;
    tri_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!m_tri_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    tri_valid = 1'b0;
    if (wait_done) begin
      n = 0;
      while (active && n < 5000) begin
        @(negedge clk);
        #1;
        n++;
      end
    end
  endtask

  initial begin : stim
    int b, n;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;

    sel = 1'b0;
    rdy_mode = 0;
    send_tri(0, 0, 4, 0, 0, 4, 15, 25, 1);
    send_tri(0, 0, 0, 4, 4, 0, 3, 25, 1);
    rdy_mode = 2;
    send_tri(0, 0, 4, 0, 0, 4, 15, 25, 1);
    rdy_mode = 0;
    send_tri(7, 9, 7, 9, 7, 9, 1, 1, 1);
    send_tri(2047, 2047, 2045, 2047, 2047, 2044, -1, 12, 1);

    @(posedge clk);
    #1 sel = 1'b1;
    send_tri(0, 0, 4, 0, 0, 4, 15, 15, 1);
    send_tri(7, 9, 7, 9, 7, 9, 1, 1, 1);

    for (int s = 0; s < 2; s++) begin
      @(posedge clk);
      #1 sel = s[0];
      rdy_mode = 1;
      for (int k = 0; k < 15; k++) begin
        case ($urandom_range(0, 2))
          0: b = 0;
          1: b = $urandom_range(0, 2039);
          default: b = 2039;
        endcase
        send_tri(b + $urandom_range(0, 8), b + $urandom_range(0, 8), b + $urandom_range(0, 8),
                 b + $urandom_range(0, 8), b + $urandom_range(0, 8), b + $urandom_range(0, 8),
                 -1, -1, 1);
      end
      rdy_mode = 0;
    end

    @(posedge clk);
    #1 sel = 1'b0;
    rdy_mode = 3;
    send_tri(0, 0, 4, 0, 0, 4, -1, -1, 0);
    n = 0;
    while (!m_pix_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    rdy_mode = 0;
    send_tri(1, 1, 3, 1, 1, 3, 6, 9, 1);

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : global_timeout
    #3000000;
    $display("FAIL global_timeout: simulation exceeded time budget, errors=%0d", errors);
    $fatal(1, "time budget exhausted");
  end

endmodule
